wave_seq_ctrl: RTL
==================

// Module: wave_seq_ctrl
// PURPOSE
//  Playlist sequencer for the waveform generator.
//  - Software loads up to DEPTH entries of {wave_type, duration} through a valid/ready port.
//  - On start, the block plays the entries in order: it drives the generator's en, cmd_rdy
//    and wave_type so each waveform runs for duration*PRESC clocks, optionally looping.
//  - Sits between the command front-end (UART/register decoder) and the generator.
// PARAMETERS
//  DEPTH  4    playlist entries (power of 2, >=2)
//  DUR_W  16   width of per-entry duration, in ticks
//  PRESC  100  clk cycles per duration tick (>=1)
// PORTS
//  clk            in   1      system clock, 100 MHz
//  rst            in   1      synchronous, active-high reset
//  cmd_valid      in   1      playlist write request
//  cmd_ready      out  1      write accepted when cmd_valid&&cmd_ready
//  cmd_type       in   8      wave type: 1=SAWTOOTH, 2=TRIANGLE, 3=SQUARE
//  cmd_dur        in   DUR_W  entry duration in ticks (0 is treated as 1)
//  clear          in   1      empty the playlist (honoured in IDLE only)
//  start          in   1      begin playback (pulse)
//  stop           in   1      abort playback (pulse)
//  loop_en        in   1      1 = wrap from last entry to entry 0
//  gen_en         out  1      to generator en
//  gen_cmd_rdy    out  1      to generator cmd_rdy (1-cycle pulse)
//  gen_wave_type  out  8      to generator wave_type
//  busy           out  1      state != IDLE
//  done           out  1      1-cycle pulse when a non-looping playlist finishes
//  cur_idx        out  log2(DEPTH)  entry currently playing (0 in IDLE)
//  err            out  1      1-cycle pulse when a write with an illegal type is dropped
// BEHAVIOUR
//  - All outputs are registered. Reset (rst sampled high): state=IDLE, count=0, cur_idx=0.
//    All outputs are 0 except cmd_ready=1.
//  - cmd_ready = (state==IDLE) && (count<DEPTH).
//    - A legal write stores the entry at index count; count++.
//    - cmd_type outside 1..3: the handshake completes, the entry is not stored, err pulses.
//  - clear in IDLE: count<=0 next cycle. clear is ignored outside IDLE.
//    If clear and a write occur in the same cycle, clear wins.
//  - FSM IDLE -> LOAD -> RUN:
//    - IDLE: start && count>0 -> LOAD, cur_idx=0. start with count==0 is ignored, state stays IDLE.
//      A write in the same cycle as start is accepted and belongs to the playlist.
//    - LOAD (exactly 1 cycle):
//      - gen_en=1, gen_cmd_rdy=1, gen_wave_type=entry[cur_idx].type.
//      - Load dur_cnt=max(dur,1), clear the prescaler -> RUN.
//    - RUN: gen_en=1, gen_cmd_rdy=0, gen_wave_type held.
//      - The prescaler counts 0..PRESC-1; a tick fires at PRESC-1 and dur_cnt decrements.
//      - On the tick where dur_cnt==1:
//        - If cur_idx<count-1: cur_idx++ -> LOAD.
//        - Else if loop_en (sampled at that cycle): cur_idx=0 -> LOAD.
//        - Else: -> IDLE with done=1 for 1 cycle.
//  - Latency: start sampled at edge k -> gen_cmd_rdy visible after edge k+1.
//    Each entry occupies exactly 1 + max(dur,1)*PRESC cycles.
//  - stop (any state): -> IDLE next edge, gen_en=0, gen_cmd_rdy=0, cur_idx=0.
//    - The playlist is retained; no done pulse.
//    - stop wins over start and over the last-tick transition.
//  - start while busy: ignored.
//  - gen_wave_type retains its last value in IDLE (the generator is disabled, so the value is harmless).
//  - Width rules: dur_cnt is DUR_W bits; the prescaler is $clog2(PRESC) bits, min 1; count is log2(DEPTH)+1 bits.
// STRUCTURE
//  - Shared package wave_pkg holds:
//    - Wave-type constants: SAWTOOTH=8'd1, TRIANGLE=8'd2, SQUARE=8'd3.
//    - The FSM state encoding: IDLE/LOAD/RUN.
//    - is_legal_type() helper.
//  - Sub-module wave_tick_gen (PRESC counter with clr input and tick output).
//    The playlist is a DEPTH x (8+DUR_W) register array inside this block.
// TESTING
//  1. Reset: assert rst 2 cycles -> gen_en=0, busy=0, cmd_ready=1, count=0, done=0.
//  2. PRESC=4: load {1,3}, {3,2}; start -> gen_cmd_rdy at k+1 with type 1; second gen_cmd_rdy
//     13 cycles later with type 3; done 9 cycles after that; then busy=0.
//  3. loop_en=1 with 2 entries -> cur_idx sequence 0,1,0,1 with no done pulse.
//     stop mid-RUN -> gen_en=0 next cycle, count unchanged.
//  4. Fill DEPTH entries -> cmd_ready=0; a further cmd_valid is not accepted.
//     Write type 8'd7 on an empty list -> err pulse, count stays 0, start is ignored.
//  5. dur=0 entry -> plays for 1+PRESC cycles.
//     start and stop in the same cycle -> stays IDLE.
//     clear with a write in the same cycle -> count=0.
//  6. rst asserted mid-RUN -> all outputs at reset values next cycle, playlist emptied.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform playlist sequencer.
//   - Wave-type codes understood by the generator.
//   - Sequencer FSM state encoding.
//   - is_legal_type(): true for the wave types the generator can play.
package wave_pkg;

  localparam logic [7:0] SAWTOOTH = 8'd1;
  localparam logic [7:0] TRIANGLE = 8'd2;
  localparam logic [7:0] SQUARE   = 8'd3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  function automatic logic is_legal_type(input logic [7:0] t);
    return (t == SAWTOOTH) || (t == TRIANGLE) || (t == SQUARE);
  endfunction

endpackage

// File: rtl/wave_tick_gen.sv
// Prescaler for the playlist sequencer: counts 0..PRESC-1 while en is high
// and raises tick during the PRESC-1 cycle.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       restart the count from 0 (takes priority over en)
//   en        advance the count
//   tick      high while en and the count sits at PRESC-1
module wave_tick_gen #(
  parameter int unsigned PRESC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == PW'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/wave_seq_ctrl.sv
// Playlist sequencer for the waveform generator.
// Software writes up to DEPTH {wave_type, duration} entries; on start the
// entries are played in order, each for 1 + max(dur,1)*PRESC cycles,
// optionally wrapping back to entry 0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           playlist write handshake
//   cmd_type, cmd_dur             entry contents (dur 0 plays as 1)
//   clear                         empty the playlist (IDLE only)
//   start, stop                   begin / abort playback (pulses)
//   loop_en                       wrap from last entry to entry 0
//   gen_en, gen_cmd_rdy,
//   gen_wave_type                 generator control
//   busy, done, cur_idx, err      status
module wave_seq_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DUR_W = 16,
  parameter int unsigned PRESC = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_type,
  input  logic [DUR_W-1:0]         cmd_dur,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic                     gen_en,
  output logic                     gen_cmd_rdy,
  output logic [7:0]               gen_wave_type,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic                     err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [CW-1:0]    count, count_n;
  logic [DUR_W-1:0] dur_cnt;
  logic [7:0]       pl_type [DEPTH];
  logic [DUR_W-1:0] pl_dur  [DEPTH];

  logic hs, legal, store, fin, tick, last_tick, done_pend;

  assign hs        = cmd_valid && cmd_ready;
  assign legal     = is_legal_type(cmd_type);
  assign last_tick = tick && (dur_cnt == DUR_W'(1));

  wave_tick_gen #(
    .PRESC(PRESC)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state == LOAD),
    .en  (state == RUN),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    count_n = count;
    store   = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          count_n = '0;
        end else if (hs && legal) begin
          store   = 1'b1;
          count_n = count + CW'(1);
        end
        // A write landing in the same cycle as start already counts.
        if (start && (count_n != '0)) begin
          state_n = LOAD;
          idx_n   = '0;
        end
      end
      LOAD: state_n = RUN;
      RUN: begin
        if (last_tick) begin
          if ((CW'(idx) + CW'(1)) < count) begin
            idx_n   = idx + IW'(1);
            state_n = LOAD;
          end else if (loop_en) begin
            idx_n   = '0;
            state_n = LOAD;
          end else begin
            idx_n   = '0;
            state_n = IDLE;
            fin     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
      fin     = 1'b0;
    end
  end

  // Playlist storage; emptiness is tracked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (store) begin
      pl_type[count[IW-1:0]] <= cmd_type;
      pl_dur[count[IW-1:0]]  <= cmd_dur;
    end
  end

  // Outputs trail the FSM state by one register stage, except that stop
  // clears the generator controls at the same edge it returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      count         <= '0;
      dur_cnt       <= '0;
      done_pend     <= 1'b0;
      cmd_ready     <= 1'b1;
      gen_en        <= 1'b0;
      gen_cmd_rdy   <= 1'b0;
      gen_wave_type <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cur_idx       <= '0;
      err           <= 1'b0;
    end else begin
      idx   <= idx_n;
      count <= count_n;
      if (state == LOAD) begin
        dur_cnt <= (pl_dur[idx] == '0) ? DUR_W'(1) : pl_dur[idx];
      end else if (tick) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end
      done_pend   <= fin;
      done        <= done_pend;
      cmd_ready   <= (state_n == IDLE) && (count_n < CW'(DEPTH));
      gen_en      <= !stop && (state != IDLE);
      gen_cmd_rdy <= !stop && (state == LOAD);
      if (!stop && (state == LOAD)) begin
        gen_wave_type <= pl_type[idx];
      end
      busy    <= (state_n != IDLE);
      cur_idx <= stop ? '0 : idx;
      err     <= hs && !legal;
    end
  end

endmodule
